// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode encodings, ALU operation codes and the
// control bundle produced by the decode stage.
package pipeline_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_SLTI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_AND = 6'h24;
  localparam logic [5:0] ALU_OR  = 6'h25;
  localparam logic [5:0] ALU_SLT = 6'h2A;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       mem_to_reg;
    logic [5:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: synchronous clear on reset, register 0 hard-wired to
// zero, combinational reads with same-cycle write-back bypass.
module register_file
  import pipeline_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];
  logic        wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      regs_d = '{default: '0};
    end else if (wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    rdata1 = regs_q[raddr1];
    if (raddr1 == 5'd0) begin
      rdata1 = '0;
    end else if (wr_en && (waddr == raddr1)) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = regs_q[raddr2];
    if (raddr2 == 5'd0) begin
      rdata2 = '0;
    end else if (wr_en && (waddr == raddr2)) begin
      rdata2 = wdata;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register read with bypass, control decode,
// immediate sign-extension and load-use hazard detection.
module id_stage
  import pipeline_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int PCW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    instruction,
  input  logic [PCW-1:0] pc_next_in,
  input  logic           wb_reg_write,
  input  logic [4:0]     wb_addr,
  input  logic [31:0]    wb_data,
  input  logic           ex_mem_read,
  input  logic [4:0]     ex_rt,
  output logic [5:0]     alu_op,
  output logic           reg_dst,
  output logic           alu_src,
  output logic           branch,
  output logic           mem_write,
  output logic           mem_read,
  output logic           reg_write,
  output logic           mem_to_reg,
  output logic [PCW-1:0] pc_next,
  output logic [31:0]    data1,
  output logic [31:0]    data2,
  output logic [31:0]    sign_extend,
  output logic [4:0]     reg1,
  output logic [4:0]     reg2,
  output logic           stall
);

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] rf_data1;
  logic [31:0] rf_data2;
  logic        hazard;
  ctrl_t       ctrl_dec;
  ctrl_t       ctrl_out;

  assign rs = instruction[25:21];
  assign rt = instruction[20:16];
  assign rd = instruction[15:11];

  register_file #(.NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs),
    .raddr2 (rt),
    .we     (wb_reg_write),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .rdata1 (rf_data1),
    .rdata2 (rf_data2)
  );

  always_comb begin
    ctrl_dec = CTRL_NOP;
    case (opcode_e'(instruction[31:26]))
      OP_RTYPE: begin
        ctrl_dec.reg_dst   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = instruction[5:0];
      end
      OP_LW: begin
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
        ctrl_dec.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = ALU_SUB;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        case (opcode_e'(instruction[31:26]))
          OP_ANDI: ctrl_dec.alu_op = ALU_AND;
          OP_ORI:  ctrl_dec.alu_op = ALU_OR;
          OP_SLTI: ctrl_dec.alu_op = ALU_SLT;
          default: ctrl_dec.alu_op = ALU_ADD;
        endcase
      end
      default: ctrl_dec = CTRL_NOP;
    endcase
  end

  // Conservative: rt is compared even for opcodes that do not read it.
  assign hazard = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == rs) || (ex_rt == rt));

  always_comb begin
    ctrl_out = (rst || hazard) ? CTRL_NOP : ctrl_dec;
  end

  assign alu_op      = ctrl_out.alu_op;
  assign reg_dst     = ctrl_out.reg_dst;
  assign alu_src     = ctrl_out.alu_src;
  assign branch      = ctrl_out.branch;
  assign mem_write   = ctrl_out.mem_write;
  assign mem_read    = ctrl_out.mem_read;
  assign reg_write   = ctrl_out.reg_write;
  assign mem_to_reg  = ctrl_out.mem_to_reg;
  assign stall       = rst ? 1'b0 : hazard;
  assign pc_next     = rst ? '0 : pc_next_in;
  assign data1       = rst ? '0 : rf_data1;
  assign data2       = rst ? '0 : rf_data2;
  assign sign_extend = rst ? '0 : {{16{instruction[15]}}, instruction[15:0]};
  assign reg1        = rst ? '0 : rt;
  assign reg2        = rst ? '0 : rd;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed test-plan steps followed by
// randomized traffic compared against a table-driven behavioural model.
module tb_id_stage;

  localparam int PCW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [31:0]    instruction;
  logic [PCW-1:0] pc_next_in;
  logic           wb_reg_write;
  logic [4:0]     wb_addr;
  logic [31:0]    wb_data;
  logic           ex_mem_read;
  logic [4:0]     ex_rt;
  logic [5:0]     alu_op;
  logic           reg_dst, alu_src, branch, mem_write, mem_read, reg_write, mem_to_reg;
  logic [PCW-1:0] pc_next;
  logic [31:0]    data1, data2, sign_extend;
  logic [4:0]     reg1, reg2;
  logic           stall;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_regs [32];
  logic [12:0] ctrl_tab   [64];

  always #5 clk = ~clk;

  id_stage #(.NREGS(32), .PCW(PCW)) dut (
    .clk          (clk),
    .rst          (rst),
    .instruction  (instruction),
    .pc_next_in   (pc_next_in),
    .wb_reg_write (wb_reg_write),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .alu_op       (alu_op),
    .reg_dst      (reg_dst),
    .alu_src      (alu_src),
    .branch       (branch),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .pc_next      (pc_next),
    .data1        (data1),
    .data2        (data2),
    .sign_extend  (sign_extend),
    .reg1         (reg1),
    .reg2         (reg2),
    .stall        (stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_reg_write && wb_addr == a) return wb_data;
    return model_regs[a];
  endfunction

  // Compare every output against the model for the current inputs.
  task automatic check_all(input string step);
    logic [4:0]  rs, rt;
    logic        exp_stall;
    logic [12:0] exp_ctrl;
    rs = instruction[25:21];
    rt = instruction[20:16];
    exp_ctrl = ctrl_tab[instruction[31:26]];
    if (instruction[31:26] == 6'h00) exp_ctrl[5:0] = instruction[5:0];
    exp_stall = ex_mem_read && ex_rt != 0 && (ex_rt == rs || ex_rt == rt);
    if (exp_stall) exp_ctrl = '0;
    if (rst) begin
      check({step, ".ctrl"},  {19'd0, reg_dst, alu_src, branch, mem_write, mem_read, reg_write, mem_to_reg, alu_op}, 32'd0);
      check({step, ".stall"}, {31'd0, stall}, 32'd0);
      check({step, ".pc"},    {24'd0, pc_next}, 32'd0);
      check({step, ".data1"}, data1, 32'd0);
      check({step, ".data2"}, data2, 32'd0);
      check({step, ".sext"},  sign_extend, 32'd0);
      check({step, ".regs"},  {22'd0, reg1, reg2}, 32'd0);
    end else begin
      check({step, ".ctrl"},  {19'd0, reg_dst, alu_src, branch, mem_write, mem_read, reg_write, mem_to_reg, alu_op}, {19'd0, exp_ctrl});
      check({step, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
      check({step, ".pc"},    {24'd0, pc_next}, {24'd0, pc_next_in});
      check({step, ".data1"}, data1, model_read(rs));
      check({step, ".data2"}, data2, model_read(rt));
      check({step, ".sext"},  sign_extend, $signed(instruction[15:0]));
      check({step, ".regs"},  {22'd0, reg1, reg2}, {22'd0, rt, instruction[15:11]});
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (wb_reg_write && wb_addr != 0) begin
      model_regs[wb_addr] = wb_data;
    end
  endtask

  task automatic settle(input string step);
    @(negedge clk);
    check_all(step);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic [5:0] ops [8];
    for (int i = 0; i < 64; i++) ctrl_tab[i] = '0;
    ctrl_tab[6'h00] = {7'b1000010, 6'h00};
    ctrl_tab[6'h23] = {7'b0100111, 6'h20};
    ctrl_tab[6'h2B] = {7'b0101000, 6'h20};
    ctrl_tab[6'h04] = {7'b0010000, 6'h22};
    ctrl_tab[6'h08] = {7'b0100010, 6'h20};
    ctrl_tab[6'h0C] = {7'b0100010, 6'h24};
    ctrl_tab[6'h0D] = {7'b0100010, 6'h25};
    ctrl_tab[6'h0A] = {7'b0100010, 6'h2A};
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A};
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    // Reset, with a hazard pattern present to confirm stall is suppressed.
    rst = 1'b1; instruction = 32'h8C220004; pc_next_in = 8'h5A;
    wb_reg_write = 1'b1; wb_addr = 5'd4; wb_data = 32'h1111_2222;
    ex_mem_read = 1'b1; ex_rt = 5'd2;
    settle("reset0"); advance();
    settle("reset1");
    check("reset.stall", {31'd0, stall}, 32'd0);
    advance();

    rst = 1'b0; wb_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    instruction = 32'h0084_0020;
    settle("post_reset");
    check("post_reset.r4", data1, 32'd0);
    advance();

    // Write r5 with same-cycle bypass, then read from the array.
    instruction = 32'h00A00020;
    wb_reg_write = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    settle("bypass");
    check("bypass.data1", data1, 32'hDEADBEEF);
    advance();
    wb_reg_write = 1'b0;
    settle("array");
    check("array.data1", data1, 32'hDEADBEEF);
    advance();

    instruction = 32'h00000020;
    wb_reg_write = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
    settle("r0_write");
    check("r0_write.data1", data1, 32'd0);
    advance();
    wb_reg_write = 1'b0;
    settle("r0_read");
    check("r0_read.data2", data2, 32'd0);
    advance();

    instruction = 32'h8C22FFFC;
    settle("lw");
    check("lw.bits", {28'd0, alu_src, mem_read, reg_write, mem_to_reg}, 32'hF);
    check("lw.others", {29'd0, reg_dst, branch, mem_write}, 32'd0);
    check("lw.alu_op", {26'd0, alu_op}, 32'h20);
    check("lw.sext", sign_extend, 32'hFFFFFFFC);
    check("lw.reg1", {27'd0, reg1}, 32'd2);
    advance();

    instruction = 32'h10220003;
    settle("beq");
    check("beq.branch", {31'd0, branch}, 32'd1);
    check("beq.alu_op", {26'd0, alu_op}, 32'h22);
    advance();

    instruction = 32'hFC000000;
    settle("unknown");
    check("unknown.ctrl", {25'd0, reg_dst, alu_src, branch, mem_write, mem_read, reg_write, mem_to_reg}, 32'd0);
    advance();

    // Load-use stall with a write-back committing in the same cycle.
    instruction = 32'h00430820; ex_mem_read = 1'b1; ex_rt = 5'd2;
    wb_reg_write = 1'b1; wb_addr = 5'd3; wb_data = 32'd7;
    settle("stall");
    check("stall.stall", {31'd0, stall}, 32'd1);
    check("stall.ctrl", {19'd0, reg_dst, alu_src, branch, mem_write, mem_read, reg_write, mem_to_reg, alu_op}, 32'd0);
    advance();
    wb_reg_write = 1'b0; ex_rt = 5'd0;
    settle("ex_rt0");
    check("ex_rt0.stall", {31'd0, stall}, 32'd0);
    advance();
    ex_mem_read = 1'b0;
    settle("after_stall");
    check("after_stall.data2", data2, 32'd7);
    check("after_stall.reg_write", {31'd0, reg_write}, 32'd1);
    advance();

    // Reset asserted during a stall.
    ex_mem_read = 1'b1; ex_rt = 5'd3;
    settle("pre_rst_stall");
    rst = 1'b1;
    settle("rst_in_stall");
    advance();
    rst = 1'b0; ex_mem_read = 1'b0;
    settle("rst_release");
    check("rst_release.data2", data2, 32'd0);
    advance();

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 6'($urandom);
      instruction  = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      pc_next_in   = 8'($urandom);
      wb_reg_write = 1'($urandom);
      wb_addr      = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      ex_mem_read  = ($urandom_range(0, 3) == 0);
      ex_rt        = 5'($urandom_range(0, 7));
      rst          = ($urandom_range(0, 59) == 0);
      settle("rand");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
